// File: rtl/definitions_pkg.sv
// Shared UART definitions: transmitter state and parity encodings, frame-length
// limits and the timing constants used by benches.
package definitions_pkg;

  localparam int CLOCK_PERIOD_NANOS = 10;
  localparam int DIVISOR            = 3;

  localparam int TX_MIN_BITS = 5;
  localparam int TX_MAX_BITS = 9;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10,
    MARK = 2'b11
  } parity_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter; rdata is the head entry
// whenever empty is low, and full is a registered flag.
module uart_tx_fifo #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_d;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (do_push && !do_pop)
      count_d = count + (AW+1)'(1);
    else if (!do_push && do_pop)
      count_d = count - (AW+1)'(1);
  end

  // Full is taken from the next count so tx_ready never sees tx_valid combinationally.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_param.sv
// FIFO-buffered UART transmitter with per-frame data length (5..9), parity mode
// and stop-bit count, latched when each word is popped.
module uart_tx_param
  import definitions_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        s_tick,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic [3:0]                  cfg_data_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_out
);

  localparam int            TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  tx_state_e         state, state_d;
  logic [TW-1:0]     tick_cnt, tick_d;
  logic [3:0]        bit_cnt, bit_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [3:0]        nbits, nbits_d;
  parity_e           par_mode, par_mode_d;
  logic              stop2, stop2_d;
  logic              par_bit, par_bit_d;
  logic              tx_d;
  logic              pop;
  logic              bit_end;
  logic              cfg_ok;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic [3:0] n,
                                       input parity_e mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(n)) x = x ^ d[i];
    case (mode)
      EVEN:    calc_parity = x;
      ODD:     calc_parity = ~x;
      default: calc_parity = 1'b1;
    endcase
  endfunction

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (tx_valid && tx_ready),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign tx_ready = !full;
  assign busy     = (state != IDLE) || !empty;
  assign bit_end  = s_tick && (tick_cnt == TICK_LAST);
  assign cfg_ok   = (cfg_data_bits >= 4'(TX_MIN_BITS)) && (cfg_data_bits <= 4'(TX_MAX_BITS));

  always_comb begin
    state_d    = state;
    tick_d     = tick_cnt;
    bit_d      = bit_cnt;
    shreg_d    = shreg;
    nbits_d    = nbits;
    par_mode_d = par_mode;
    stop2_d    = stop2;
    par_bit_d  = par_bit;
    pop        = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    tx_d       = 1'b1;

    if (s_tick) tick_d = bit_end ? '0 : tick_cnt + TW'(1);

    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (cfg_ok) begin
            state_d    = START;
            tick_d     = '0;
            bit_d      = '0;
            shreg_d    = head;
            nbits_d    = cfg_data_bits;
            par_mode_d = parity_e'(cfg_parity);
            stop2_d    = cfg_stop2;
            par_bit_d  = calc_parity(head, cfg_data_bits, parity_e'(cfg_parity));
          end else begin
            err = 1'b1;
          end
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == nbits - 4'd1) begin
            state_d = (par_mode != NONE) ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_cnt + 4'd1;
            shreg_d = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == {3'b000, stop2}) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            bit_d = bit_cnt + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is registered from the state being entered.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx_out   <= 1'b1;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_d;
      bit_cnt  <= bit_d;
      tx_out   <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg    <= shreg_d;
    nbits    <= nbits_d;
    par_mode <= par_mode_d;
    stop2    <= stop2_d;
    par_bit  <= par_bit_d;
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: a tick-counting line receiver decodes frames, which
// are compared against frames built from data and configuration.
module tb_uart_tx_param;
  import definitions_pkg::*;

  localparam int DATA_W     = 9;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              s_tick = 1'b0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data = '0;
  logic [3:0]        cfg_data_bits = 4'd8;
  logic [1:0]        cfg_parity = 2'b00;
  logic              cfg_stop2 = 1'b0;
  logic              busy, done, err, tx_out;
  logic [CW-1:0]     fifo_count;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;
  int cyc    = 0;
  int tick_div = DIVISOR;
  bit tick_en  = 1'b1;

  uart_tx_param #(
    .DATA_W     (DATA_W),
    .OVERSAMPLE (OVERSAMPLE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .s_tick        (s_tick),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .fifo_count    (fifo_count),
    .tx_out        (tx_out)
  );

  always #(CLOCK_PERIOD_NANOS / 2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (err)  n_err  <= n_err + 1;
  end

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        div++;
        if (div >= tick_div) begin
          s_tick = 1'b1;
          div = 0;
        end else begin
          s_tick = 1'b0;
        end
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #(CLOCK_PERIOD_NANOS * 90000);
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference frame: start 0, data LSB first, optional parity, then idle-high stop bits.
  function automatic int frame_len(input int n, input int p, input bit s2);
    return 1 + n + int'(p != 0) + (s2 ? 2 : 1);
  endfunction

  function automatic logic [15:0] frame_bits(input logic [DATA_W-1:0] d, input int n,
                                             input int p, input bit s2);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (p == 1)      f[1+n] = ones[0];
    else if (p == 2) f[1+n] = ~ones[0];
    else if (p == 3) f[1+n] = 1'b1;
    return f;
  endfunction

  task automatic rx_frame(input int len, input bit scramble, output logic [15:0] bits,
                          output int t_fall, output bit ok);
    int n, k, guard;
    bits = '1;
    ok = 1'b0;
    t_fall = 0;
    guard = 0;
    while (tx_out !== 1'b0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) return;
    t_fall = cyc;
    if (scramble) begin
      cfg_data_bits = 4'($urandom);
      cfg_parity    = 2'($urandom);
      cfg_stop2     = 1'($urandom);
    end
    n = 0;
    k = 0;
    guard = 0;
    while (k < len && guard < 20000) begin
      if (s_tick) begin
        n++;
        @(negedge clk);
        if (n == OVERSAMPLE * k + OVERSAMPLE / 2) begin
          bits[k] = tx_out;
          k++;
        end
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    ok = (k == len);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d, output bit ok);
    int guard;
    guard = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (tx_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 5000);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 20000) begin
      @(negedge clk);
      g++;
    end
    ok = (g < 20000);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (tx_out !== 1'b1)     begin errors++; $display("FAIL reset tx_out got %b want 1", tx_out); end
    checks++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL reset tx_ready got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset done got %b want 0", done); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset err got %b want 0", err); end
    checks++; if (fifo_count !== '0)   begin errors++; $display("FAIL reset fifo_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_frame(input string name, input logic [DATA_W-1:0] d, input int n,
                            input int p, input bit s2, input bit scramble);
    logic [15:0] got, exp;
    int tf, d0, e0, len;
    bit ok, ok2, ok3;
    d0  = n_done;
    e0  = n_err;
    len = frame_len(n, p, s2);
    exp = frame_bits(d, n, p, s2);
    cfg_data_bits = 4'(n);
    cfg_parity    = 2'(p);
    cfg_stop2     = s2;
    push_word(d, ok);
    rx_frame(len, scramble, got, tf, ok2);
    checks++;
    if (!ok || !ok2 || got !== exp) begin
      errors++;
      $display("FAIL %s frame bits got %h want %h (push %0b rx %0b)", name, got, exp, ok, ok2);
    end
    wait_idle(ok3);
    checks++; if (!ok3 || n_done - d0 != 1) begin errors++; $display("FAIL %s done pulses got %0d want 1", name, n_done - d0); end
    checks++; if (n_err != e0)             begin errors++; $display("FAIL %s err pulses got %0d want 0", name, n_err - e0); end
    checks++; if (busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++; $display("FAIL %s idle after frame busy %b tx_out %b want 0 1", name, busy, tx_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      test_frame("random", DATA_W'($urandom), int'($urandom_range(5, 9)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic test_illegal();
    logic [3:0] bad [2];
    int d0, e0;
    bit ok, low_seen;
    bad[0] = 4'd4;
    bad[1] = 4'd12;
    for (int i = 0; i < 2; i++) begin
      d0 = n_done;
      e0 = n_err;
      low_seen = 1'b0;
      cfg_data_bits = bad[i];
      cfg_parity = 2'b00;
      cfg_stop2 = 1'b0;
      push_word(9'h00F, ok);
      repeat (60) begin
        @(negedge clk);
        if (tx_out !== 1'b1) low_seen = 1'b1;
      end
      checks++; if (!ok || n_err - e0 != 1) begin errors++; $display("FAIL illegal err pulses got %0d want 1", n_err - e0); end
      checks++; if (low_seen)               begin errors++; $display("FAIL illegal tx_out went low, want steady 1"); end
      checks++; if (fifo_count !== '0)      begin errors++; $display("FAIL illegal fifo_count got %0d want 0", fifo_count); end
      checks++; if (n_done != d0 || busy !== 1'b0) begin
        errors++; $display("FAIL illegal done %0d busy %b want 0 0", n_done - d0, busy);
      end
    end
  endtask

  task automatic test_freeze();
    logic [15:0] got, exp;
    logic [DATA_W-1:0] d;
    logic held;
    int tf, d0;
    bit ok, ok2, ok3, changed;
    d = DATA_W'($urandom);
    d0 = n_done;
    changed = 1'b0;
    held = 1'b1;
    cfg_data_bits = 4'd8;
    cfg_parity = 2'b01;
    cfg_stop2 = 1'b0;
    exp = frame_bits(d, 8, 1, 1'b0);
    push_word(d, ok);
    fork
      rx_frame(frame_len(8, 1, 1'b0), 1'b0, got, tf, ok2);
      begin
        repeat (150) @(negedge clk);
        tick_en = 1'b0;
        @(negedge clk);
        held = tx_out;
        repeat (80) begin
          @(negedge clk);
          if (tx_out !== held) changed = 1'b1;
        end
        tick_en = 1'b1;
      end
    join
    checks++; if (changed) begin errors++; $display("FAIL freeze tx_out moved without ticks, held %b", held); end
    checks++; if (!ok || !ok2 || got !== exp) begin errors++; $display("FAIL freeze frame got %h want %h", got, exp); end
    wait_idle(ok3);
    checks++; if (!ok3 || n_done - d0 != 1) begin errors++; $display("FAIL freeze done pulses got %0d want 1", n_done - d0); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w [10];
    logic [15:0] got [10];
    int tf [10];
    bit okr [10];
    int n, p, len, d0, e0, bad_count, guard;
    bit s2, ok, blocked, push_to;
    n  = int'($urandom_range(5, 9));
    p  = int'($urandom_range(0, 3));
    s2 = 1'($urandom_range(0, 1));
    len = frame_len(n, p, s2);
    for (int i = 0; i < 10; i++) w[i] = DATA_W'($urandom);
    cfg_data_bits = 4'(n);
    cfg_parity = 2'(p);
    cfg_stop2 = s2;
    tick_div = 1;
    d0 = n_done;
    e0 = n_err;
    bad_count = 0;
    blocked = 1'b0;
    push_to = 1'b0;
    fork
      begin
        @(negedge clk);
        tx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
          tx_data = w[i];
          guard = 0;
          while (tx_ready !== 1'b1 && guard < 5000) begin
            if (fifo_count !== CW'(FIFO_DEPTH)) bad_count++;
            if (i == 9) blocked = 1'b1;
            @(negedge clk);
            guard++;
          end
          if (guard >= 5000) push_to = 1'b1;
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
      for (int i = 0; i < 10; i++) rx_frame(len, 1'b0, got[i], tf[i], okr[i]);
    join
    checks++; if (!blocked || push_to) begin errors++; $display("FAIL b2b tenth push blocked %b timeout %b want 1 0", blocked, push_to); end
    checks++; if (bad_count != 0) begin errors++; $display("FAIL b2b fifo_count not %0d while not ready in %0d cycles", FIFO_DEPTH, bad_count); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (!okr[i] || got[i] !== frame_bits(w[i], n, p, s2)) begin
        errors++; $display("FAIL b2b frame %0d got %h want %h", i, got[i], frame_bits(w[i], n, p, s2));
      end
      if (i > 0) begin
        checks++;
        if (tf[i] - tf[i-1] != len * OVERSAMPLE + 1) begin
          errors++; $display("FAIL b2b spacing %0d got %0d clk want %0d", i, tf[i] - tf[i-1], len * OVERSAMPLE + 1);
        end
      end
    end
    wait_idle(ok);
    checks++; if (!ok || n_done - d0 != 10) begin errors++; $display("FAIL b2b done pulses got %0d want 10", n_done - d0); end
    checks++; if (n_err != e0) begin errors++; $display("FAIL b2b err pulses got %0d want 0", n_err - e0); end
    tick_div = DIVISOR;
  endtask

  task automatic test_reset_midframe();
    int d0, e0;
    bit ok, ok2, low_seen;
    cfg_data_bits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    d0 = n_done;
    e0 = n_err;
    low_seen = 1'b0;
    push_word(9'h000, ok);
    push_word(9'h1AB, ok2);
    repeat (200) @(negedge clk);
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL midreset line before reset got %b want 0", tx_out); end
    #2;
    rstN = 1'b0;
    #1;
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL midreset async tx_out got %b want 1", tx_out); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL midreset fifo_count got %0d want 0", fifo_count); end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (700) begin
      @(negedge clk);
      if (tx_out !== 1'b1) low_seen = 1'b1;
    end
    checks++; if (!ok || !ok2 || low_seen) begin errors++; $display("FAIL midreset line activity after flush, want steady 1"); end
    checks++; if (n_done != d0 || n_err != e0) begin
      errors++; $display("FAIL midreset done %0d err %0d want 0 0", n_done - d0, n_err - e0);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_frame("8n1_a5",   9'h0A5, 8, 0, 1'b0, 1'b0);
    test_frame("7e2_35",   9'h035, 7, 1, 1'b1, 1'b0);
    test_frame("9o1_1ff",  9'h1FF, 9, 2, 1'b0, 1'b0);
    test_frame("9m1_000",  9'h000, 9, 3, 1'b0, 1'b0);
    test_random();
    test_illegal();
    test_freeze();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
